// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined mux tree.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

   // Number of input lanes for a given select width.
   function automatic int lanes(input int sel_w);
      return 1 << sel_w;
   endfunction

   // Number of lanes held in the register of level lvl (output side of that level).
   function automatic int lvl_lanes(input int sel_w, input int lvl);
      return 1 << (sel_w - 1 - lvl);
   endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: halves the lane count using select bit LVL, then registers.
// Latency: 1 cycle.
// Backpressure: skid-free register slice; ready = empty or downstream ready.
module mux_tree_stage #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3,
   parameter int LVL   = 0,
   parameter int LANES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_up_vld,
   output logic                         o_up_rdy,
   input  logic [LANES*WIDTH-1:0]       i_up_dat,
   input  logic [SEL_W-1:0]             i_up_sel,
   input  logic                         i_up_last,
   output logic                         o_dn_vld,
   input  logic                         i_dn_rdy,
   output logic [(LANES/2)*WIDTH-1:0]   o_dn_dat,
   output logic [SEL_W-1:0]             o_dn_sel,
   output logic                         o_dn_last
);

   localparam int LO = LANES / 2;

   logic                      r_vld;
   logic [LO*WIDTH-1:0]       r_dat;
   logic [SEL_W-1:0]          r_sel;
   logic                      r_last;
   logic [LO*WIDTH-1:0]       w_mux;
   logic                      w_load;

   // Pairwise 2:1 muxes; bit LVL of the carried select picks odd or even lane.
   always_comb begin
      w_mux = '0;
      for (int j = 0; j < LO; j++) begin
         w_mux[j*WIDTH +: WIDTH] = i_up_sel[LVL] ? i_up_dat[(2*j+1)*WIDTH +: WIDTH]
                                                 : i_up_dat[(2*j)*WIDTH +: WIDTH];
      end
   end

   // An empty slot accepts even when downstream stalls, so bubbles collapse.
   assign o_up_rdy = !r_vld || i_dn_rdy;
   assign w_load   = i_up_vld && o_up_rdy;

   // Register slice: valid follows upstream whenever we are ready, payload loads only on a beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_dat  <= '0;
         r_sel  <= '0;
         r_last <= 1'b0;
      end else begin
         if (o_up_rdy) begin
            r_vld <= i_up_vld;
         end
         if (w_load) begin
            r_dat  <= w_mux;
            r_sel  <= i_up_sel;
            r_last <= i_up_last;
         end
      end
   end

   assign o_dn_vld  = r_vld;
   assign o_dn_dat  = r_dat;
   assign o_dn_sel  = r_sel;
   assign o_dn_last = r_last;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux (N = 2**SEL_W) with optional round-robin auto-scan select.
// Latency: SEL_W cycles, one beat per cycle sustained.
// Backpressure: valid/ready; up to SEL_W beats buffered, in_ready comb from out_ready.
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [lanes(SEL_W)*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]              sel,
   input  logic                          auto_en,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH-1:0]              dout,
   output logic [SEL_W-1:0]              out_sel,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int N = lanes(SEL_W);

   logic [SEL_W-1:0] r_cnt;
   logic [SEL_W-1:0] w_sel_eff;
   logic             w_acc;

   // Per-level handshake and sideband; index k is the input of level k, SEL_W is the output.
   logic             w_vld  [0:SEL_W];
   logic             w_rdy  [0:SEL_W];
   logic             w_last [0:SEL_W];
   logic [SEL_W-1:0] w_sel  [0:SEL_W];

   assign w_sel_eff = auto_en ? r_cnt : sel;
   assign w_acc     = in_valid && in_ready;

   assign w_vld[0]     = in_valid;
   assign w_sel[0]     = w_sel_eff;
   assign w_last[0]    = auto_en && (w_sel_eff == SEL_W'(N - 1));
   assign w_rdy[SEL_W] = out_ready;
   assign in_ready     = w_rdy[0];

   genvar k;
   generate
      for (k = 0; k < SEL_W; k++) begin : g_lvl
         localparam int LI = 2 * lvl_lanes(SEL_W, k);

         logic [LI*WIDTH-1:0]     w_up_dat;
         logic [(LI/2)*WIDTH-1:0] w_dn_dat;

         if (k == 0) begin : g_head
            assign w_up_dat = din;
         end else begin : g_body
            assign w_up_dat = g_lvl[k-1].w_dn_dat;
         end

         mux_tree_stage #(
            .WIDTH (WIDTH),
            .SEL_W (SEL_W),
            .LVL   (k),
            .LANES (LI)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_up_vld  (w_vld[k]),
            .o_up_rdy  (w_rdy[k]),
            .i_up_dat  (w_up_dat),
            .i_up_sel  (w_sel[k]),
            .i_up_last (w_last[k]),
            .o_dn_vld  (w_vld[k+1]),
            .i_dn_rdy  (w_rdy[k+1]),
            .o_dn_dat  (w_dn_dat),
            .o_dn_sel  (w_sel[k+1]),
            .o_dn_last (w_last[k+1])
         );
      end
   endgenerate

   assign dout      = g_lvl[SEL_W-1].w_dn_dat;
   assign out_sel   = w_sel[SEL_W];
   assign out_last  = w_last[SEL_W];
   assign out_valid = w_vld[SEL_W];

   // Scan counter advances only on accepted auto-mode beats, wrapping N-1 -> 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_acc && auto_en) begin
         r_cnt <= r_cnt + SEL_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe (WIDTH=8, SEL_W=3).
// Latency: expects 3 cycles accept-to-output when unstalled.
// Backpressure: exercises stalls, bubble collapse, mid-stream reset and random traffic.
module tb_mux_tree_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] din;
   logic [2:0]  sel;
   logic        auto_en;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  dout;
   logic [2:0]  out_sel;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   mux_tree_pipe #(.WIDTH(8), .SEL_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .sel       (sel),
      .auto_en   (auto_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dout      (dout),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
      logic       l;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] mcnt;
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         n_acc = 0;
   int         n_last = 0;
   bit         lat_chk = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs already set; settles, scores both handshakes, advances one cycle.
   task automatic step();
      exp_t       e;
      logic [2:0] se;
      #1;
      if (rst) begin
         sb.delete();
         mcnt = 3'd0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_beat", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("beat", {20'd0, dout, out_sel, out_last}, {20'd0, e.d, e.s, e.l});
               if (lat_chk) check("latency", cyc - e.cyc, 32'd3);
               if (out_last) n_last++;
            end
         end
         if (in_valid && in_ready) begin
            se    = auto_en ? mcnt : sel;
            e.d   = din[se*8 +: 8];
            e.s   = se;
            e.l   = auto_en && (se == 3'd7);
            e.cyc = cyc;
            sb.push_back(e);
            if (auto_en) mcnt = mcnt + 3'd1;
            n_acc++;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_out(input string tag);
      for (int t = 0; t < 12 && !out_valid; t++) step();
      if (!out_valid) check(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int a0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      auto_en   = 1'b0;
      sel       = 3'd0;
      mcnt      = 3'd0;
      for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'h10 + 8'(i);
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_out_sel", {29'd0, out_sel}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Explicit select sweep, fixed latency
      lat_chk = 1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         sel      = 3'(i);
         step();
      end
      in_valid = 1'b0;
      repeat (5) step();
      lat_chk = 0;
      check("sweep_drain", sb.size(), 32'd0);

      // Auto scan: 10 beats, last only on lane 7
      auto_en  = 1'b1;
      n_last   = 0;
      in_valid = 1'b1;
      repeat (10) step();
      in_valid = 1'b0;
      repeat (5) step();
      check("auto_last_count", n_last, 32'd1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out("auto_resume_timeout");
      check("auto_resume_lane", {24'd0, dout}, 32'h12);
      step();

      // Backpressure: 6 stalled cycles while streaming
      auto_en   = 1'b0;
      out_ready = 1'b0;
      a0        = n_acc;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         sel      = 3'($urandom_range(0, 7));
         if (i >= 3) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold", {24'd0, dout}, {24'd0, sb[0].d});
         end
         step();
      end
      check("bp_accepts", n_acc - a0, 32'd3);
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();
      check("bp_drain", sb.size(), 32'd0);

      // Bubble collapse under a stalled sink
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel       = 3'd1;
      step();
      in_valid = 1'b0;
      step();
      step();
      in_valid = 1'b1;
      sel      = 3'd2;
      step();
      in_valid = 1'b0;
      step();
      #1;
      check("bubble_in_ready", {31'd0, in_ready}, 32'd1);
      check("bubble_head", {23'd0, out_valid, dout}, {23'd0, 1'b1, 8'h11});
      a0       = n_acc;
      in_valid = 1'b1;
      sel      = 3'd3;
      step();
      in_valid = 1'b0;
      check("bubble_third_acc", n_acc - a0, 32'd1);
      out_ready = 1'b1;
      repeat (6) step();
      check("bubble_drain", sb.size(), 32'd0);

      // Reset with three beats in flight
      auto_en  = 1'b1;
      in_valid = 1'b1;
      repeat (3) step();
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_dout", {24'd0, dout}, 32'd0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out("midrst_resume_timeout");
      check("midrst_resume", {21'd0, dout, out_sel}, {21'd0, 8'h10, 3'd0});
      step();

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         sel       = 3'($urandom_range(0, 7));
         auto_en   = ($urandom_range(0, 7) < 3);
         din       = {$urandom, $urandom};
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 20 && sb.size() != 0; t++) step();
      check("final_drain", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised N:1 multiplexer, N = 2**SEL_W, WIDTH-bit lanes.
- Built as a binary tree of 2:1 levels, with a register after each level, so it is fully pipelined.
- valid/ready handshake at both ends; throughput one beat per cycle.
- Optional auto-scan mode: an internal counter drives the select, turning the block into an N-lane round-robin serializer.
- Used wherever the team's combinational N:1 muxes need to close timing or feed a backpressured sink.

Parameters:
- WIDTH, 8, bits per input lane and output.
- SEL_W, 3, select width; N = 2**SEL_W inputs; pipeline depth = SEL_W levels (SEL_W >= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  N*WIDTH  packed lanes; lane i = din[i*WIDTH +: WIDTH].
- sel  in  SEL_W  explicit select, used when auto_en=0.
- auto_en  in  1  1 = select comes from internal scan counter.
- in_valid  in  1  din/sel valid.
- in_ready  out  1  block accepts a beat this cycle.
- dout  out  WIDTH  selected lane.
- out_sel  out  SEL_W  select value used for this beat.
- out_last  out  1  beat used select N-1 while in auto mode.
- out_valid  out  1  dout valid.
- out_ready  in  1  sink accepts dout.

Behaviour:
- Reset: synchronous, active-high. All stage valid bits = 0, out_valid = 0, dout = 0, out_sel = 0, out_last = 0, scan counter = 0. Reset asserted mid-stream discards all in-flight beats; no output beat appears on the cycle after reset.
- Effective select: sel_eff = auto_en ? cnt : sel, sampled on the accepting cycle only.
- Level k (k = 0..SEL_W-1):
  - Holds 2**(SEL_W-1-k) lanes, the unconsumed select bits sel_eff[SEL_W-1:k], out_sel and the last flag.
  - Lane j of level k = sel_eff[k] ? lane 2j+1 : lane 2j of level k-1.
  - Level 0 uses din and bit 0, so LSB-first; this matches existing 8:1 behaviour where s0 resolves first.
- Handshake: stage k ready = !valid_k || ready_(k+1), with ready_(SEL_W) = out_ready.
  - in_ready = stage-0 ready; input accepted when in_valid && in_ready.
  - A stage loads when its upstream is valid and the stage is ready. Otherwise it holds data and valid.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
  - The final level drives dout/out_sel/out_last/out_valid directly as registers; out_valid = valid_(SEL_W-1).
- Latency: exactly SEL_W cycles from acceptance to out_valid with no stall; 1 beat/cycle sustained when out_ready=1.
- Stall: with out_ready=0, dout/out_sel/out_last/out_valid stay stable until accepted. At most SEL_W beats are in flight; in_ready falls once all stages are full.
- Scan counter cnt (SEL_W bits):
  - Increments only on an accepted beat while auto_en=1, wrapping N-1 -> 0.
  - Holds its value when auto_en=0.
- out_last = auto_en_at_accept && (sel_eff == N-1).
- Toggling auto_en takes effect on the next accepted beat; beats already in flight are unaffected.
- Simultaneous accept at input and output in the same cycle is legal and required for full throughput.
- din/sel are don't-care when in_valid=0. No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.

Decomposition:
- Package mux_pkg: function lanes(SEL_W) returning 2**SEL_W; a level-width helper.
- One sub-module, mux_tree_stage. It covers one level: parametrised lane count, WIDTH and remaining select width. It contains the 2:1 lane muxes, the register slice and its valid/ready logic.
- The top instantiates SEL_W stages via generate, plus the scan counter.

Test Plan:
- WIDTH=8, SEL_W=3, lane i = 0x10+i, auto_en=0, out_ready=1; drive sel 0..7 on consecutive cycles -> dout 0x10..0x17 appear 3 cycles later, one per cycle, out_sel = 0..7, out_last = 0.
- Auto mode: auto_en=1, in_valid=1 for 10 beats -> dout 0x10..0x17, 0x10, 0x11; out_last = 1 only on the 0x17 beat; cnt = 2 at the end.
- Backpressure: out_ready=0 for 6 cycles while streaming -> in_ready falls after 3 accepts, dout stable at the first beat. On release, all beats emerge in order with none lost or duplicated.
- Bubble collapse: one beat, 2-cycle gap, second beat, out_ready held 0 -> both beats held in adjacent stages, in_ready still 1 for the third beat.
- Reset mid-stream: rst high for 1 cycle with 3 beats in flight -> out_valid = 0, dout = 0 next cycle, cnt = 0; the next auto beat selects lane 0.
- Random: randomized in_valid/out_ready/sel/auto_en for 10k cycles against a reference queue model -> every output beat matches din[sel_eff], with no drops and no reordering.
